mem_port_arbiter: RTL

- Shares one single-ported memory between the instruction-fetch stage and the memory (MEM) stage.
- Sequences each access with a request/ready handshake to the memory and returns read data to the requester.
- Raises per-requester stall flags, which the hazard unit ORs into the pipeline register write-enables.
- A watchdog aborts accesses the memory never acknowledges.

---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and the MEM stage.
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_rdata/if_stall              fetch requester
//   d_rd/d_wr/d_addr/d_wdata -> d_rdata/d_stall      load/store requester
//   m_en/m_we/m_addr/m_wdata, m_rdata/m_ready        memory handshake
//   bus_err                                          watchdog abort pulse
//   MEM_ARB_STATS_EN adds fetch_wait_cnt and data_acc_cnt (saturating)
module mem_port_arbiter #(
  parameter int N  = 32,
  parameter int TO = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [N-1:0] if_rdata,
  output logic         if_stall,
  input  logic         d_rd,
  input  logic         d_wr,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_stall,
  output logic         m_en,
  output logic         m_we,
  output logic [N-1:0] m_addr,
  output logic [N-1:0] m_wdata,
  input  logic [N-1:0] m_rdata,
  input  logic         m_ready,
  output logic         bus_err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]  fetch_wait_cnt,
  output logic [15:0]  data_acc_cnt
`endif
);
  localparam int CW = $clog2(TO);
  typedef enum logic [2:0] {IDLE, I_ACC, D_ACC, I_DONE, D_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic d_req, acc, acc_n, enter, to, done, d_sel;
  assign d_req    = d_rd | d_wr;
  assign acc      = state == I_ACC || state == D_ACC;
  assign acc_n    = state_n == I_ACC || state_n == D_ACC;
  assign enter    = acc_n & ~acc;
  assign d_sel    = state_n == D_ACC;
  // Abort on the TO-th access cycle without an acknowledge
  assign to       = acc & ~m_ready & (cnt == CW'(TO - 1));
  assign done     = acc & (m_ready | to);
  assign bus_err  = to;
  assign if_stall = if_req & (state != I_DONE);
  assign d_stall  = d_req & (state != D_DONE);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = d_req ? D_ACC : if_req ? I_ACC : IDLE;
      I_ACC:   state_n = done ? I_DONE : I_ACC;
      D_ACC:   state_n = done ? D_DONE : D_ACC;
      I_DONE:  state_n = d_req ? D_ACC : IDLE;
      D_DONE:  state_n = if_req ? I_ACC : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      cnt      <= '0;
    end else if (enter) begin
      m_en    <= 1'b1;
      m_we    <= d_sel & d_wr;
      m_addr  <= d_sel ? d_addr : if_addr;
      m_wdata <= d_sel ? d_wdata : '0;
      cnt     <= '0;
    end else if (done) begin
      m_en <= 1'b0;
      m_we <= 1'b0;
      if (state == I_ACC) if_rdata <= m_ready ? m_rdata : '0;
      else if (!m_we) d_rdata <= m_ready ? m_rdata : '0;
    end else if (acc) cnt <= cnt + 1'b1;
`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_wait_cnt <= '0;
      data_acc_cnt   <= '0;
    end else begin
      if (if_stall && fetch_wait_cnt != 16'hFFFF) fetch_wait_cnt <= fetch_wait_cnt + 16'd1;
      if (state == D_DONE && data_acc_cnt != 16'hFFFF) data_acc_cnt <= data_acc_cnt + 16'd1;
    end
`endif
endmodule
